// File: rtl/forward_ctrl_pkg.sv
// Shared constants and stage metadata for the EX-stage forwarding controller.
// The metadata rd field width must equal the controller's REG_AW.
package fwd_pkg;

    localparam int META_AW = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [META_AW-1:0] rd;
        logic               regwrite;
        logic               memread;
    } stage_meta_t;

    // x0 is hard-wired to zero, so an entry targeting it never produces a value.
    function automatic logic writes_reg(input stage_meta_t m, input logic [META_AW-1:0] r);
        return m.valid && m.regwrite && (m.rd != '0) && (m.rd == r);
    endfunction

endpackage

// File: rtl/forward_ctrl_if.sv
// ID-stage decode fields in, forwarding selects and stall request out.
interface forward_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] ID_RS1_i;
    logic [REG_AW-1:0] ID_RS2_i;
    logic              ID_RS1_Use_i;
    logic              ID_RS2_Use_i;
    logic [REG_AW-1:0] ID_RD_i;
    logic              ID_RegWrite_i;
    logic              ID_MemRead_i;
    logic              ID_Valid_i;
    logic              Flush_i;
    logic [1:0]        ForwardA_o;
    logic [1:0]        ForwardB_o;
    logic              Stall_o;
    logic [CNT_W-1:0]  StallCnt_o;

    modport master (
        output ID_RS1_i, ID_RS2_i, ID_RS1_Use_i, ID_RS2_Use_i, ID_RD_i,
               ID_RegWrite_i, ID_MemRead_i, ID_Valid_i, Flush_i,
        input  ForwardA_o, ForwardB_o, Stall_o, StallCnt_o
    );

    modport slave (
        input  ID_RS1_i, ID_RS2_i, ID_RS1_Use_i, ID_RS2_Use_i, ID_RD_i,
               ID_RegWrite_i, ID_MemRead_i, ID_Valid_i, Flush_i,
        output ForwardA_o, ForwardB_o, Stall_o, StallCnt_o
    );
endinterface

// File: rtl/forward_ctrl_select.sv
// Priority compare of one EX source register against the MEM and WB stage writers.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int REG_AW = META_AW
) (
    input  logic [REG_AW-1:0] src_i,
    input  stage_meta_t       exmem_i,
    input  stage_meta_t       memwb_i,
    output logic [1:0]        sel_o
);

    // MEM holds the younger instruction, so it shadows an older WB write.
    always_comb begin
        sel_o = FWD_NONE;
        if (writes_reg(exmem_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (writes_reg(memwb_i, src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding/hazard controller: shadows rd metadata through ID/EX, EX/MEM, MEM/WB
// and drives the EX operand selects plus the load-use stall.
module forward_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = META_AW,
    parameter int CNT_W  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    forward_ctrl_if.slave bus
);

    stage_meta_t       idex_q, idex_d;
    stage_meta_t       exmem_q, exmem_d;
    stage_meta_t       memwb_q, memwb_d;
    logic [REG_AW-1:0] idex_rs1_q, idex_rs1_d;
    logic [REG_AW-1:0] idex_rs2_q, idex_rs2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              stall;
    logic              hit_rs1;
    logic              hit_rs2;
    logic              mem_fwd_of_load;
    logic [REG_AW-1:0] src   [2];
    logic [1:0]        fwd_sel [2];

    assign src[0] = idex_rs1_q;
    assign src[1] = idex_rs2_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            fwd_select #(.REG_AW(REG_AW)) u_sel (
                .src_i   (src[gi]),
                .exmem_i (exmem_q),
                .memwb_i (memwb_q),
                .sel_o   (fwd_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        hit_rs1 = bus.ID_RS1_Use_i && (idex_q.rd == bus.ID_RS1_i);
        hit_rs2 = bus.ID_RS2_Use_i && (idex_q.rd == bus.ID_RS2_i);
        // A flushed ID instruction never needs the load, so flush suppresses the stall.
        stall   = idex_q.valid && idex_q.memread && (idex_q.rd != '0) &&
                  (hit_rs1 || hit_rs2) && bus.ID_Valid_i && !bus.Flush_i;

        exmem_d = idex_q;
        memwb_d = exmem_q;

        idex_d     = '0;
        idex_rs1_d = '0;
        idex_rs2_d = '0;
        if (!(stall || bus.Flush_i)) begin
            idex_d.valid    = bus.ID_Valid_i;
            idex_d.rd       = bus.ID_RD_i;
            idex_d.regwrite = bus.ID_RegWrite_i;
            idex_d.memread  = bus.ID_MemRead_i;
            idex_rs1_d      = bus.ID_RS1_i;
            idex_rs2_d      = bus.ID_RS2_i;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        mem_fwd_of_load = exmem_q.memread &&
                          ((fwd_sel[0] == FWD_MEM) || (fwd_sel[1] == FWD_MEM));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q     <= '0;
            exmem_q    <= '0;
            memwb_q    <= '0;
            idex_rs1_q <= '0;
            idex_rs2_q <= '0;
            cnt_q      <= '0;
        end else begin
            idex_q     <= idex_d;
            exmem_q    <= exmem_d;
            memwb_q    <= memwb_d;
            idex_rs1_q <= idex_rs1_d;
            idex_rs2_q <= idex_rs2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ForwardA_o = fwd_sel[0];
    assign bus.ForwardB_o = fwd_sel[1];
    assign bus.Stall_o    = stall;
    assign bus.StallCnt_o = cnt_q;

    // Load data is not available in MEM; the stall must have prevented this.
    a_no_mem_fwd_of_load: assert property (@(posedge clk_i) disable iff (rst_i) !mem_fwd_of_load);

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed-vector bench: driver queues expected outputs per cycle, monitor checks them.
module tb_forward_ctrl;

    localparam int CW = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    forward_ctrl_if #(.REG_AW(5), .CNT_W(CW)) bus ();

    forward_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        string         name;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    bit   drive_done = 1'b0;

    task automatic chk(input string nm, input string field, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, field, got, want);
    endtask

    task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic v, input logic fl,
                       input logic [1:0] efa, input logic [1:0] efb, input logic est, input int ecnt,
                       input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i             = 1'b0;
        bus.ID_RS1_i      = rs1;
        bus.ID_RS2_i      = rs2;
        bus.ID_RS1_Use_i  = u1;
        bus.ID_RS2_Use_i  = u2;
        bus.ID_RD_i       = rd;
        bus.ID_RegWrite_i = rw;
        bus.ID_MemRead_i  = mr;
        bus.ID_Valid_i    = v;
        bus.Flush_i       = fl;
        e.name = nm;
        e.fa   = efa;
        e.fb   = efb;
        e.st   = est;
        e.cnt  = CW'(ecnt);
        sb.push_back(e);
    endtask

    task automatic nop(input logic [1:0] efa, input logic [1:0] efb, input int ecnt, input string nm);
        ins(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, efa, efb, 1'b0, ecnt, nm);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("check %s: fa=%0d fb=%0d st=%0d cnt=%0d", e.name,
                         bus.ForwardA_o, bus.ForwardB_o, bus.Stall_o, bus.StallCnt_o);
                chk(e.name, "ForwardA", int'(bus.ForwardA_o), int'(e.fa));
                chk(e.name, "ForwardB", int'(bus.ForwardB_o), int'(e.fb));
                chk(e.name, "Stall",    int'(bus.Stall_o),    int'(e.st));
                chk(e.name, "StallCnt", int'(bus.StallCnt_o), int'(e.cnt));
            end
        end
    end

    initial begin
        int c0, c1;
        bus.ID_RS1_i = '0; bus.ID_RS2_i = '0; bus.ID_RS1_Use_i = 0; bus.ID_RS2_Use_i = 0;
        bus.ID_RD_i = '0; bus.ID_RegWrite_i = 0; bus.ID_MemRead_i = 0; bus.ID_Valid_i = 0;
        bus.Flush_i = 0;
        repeat (2) @(posedge clk_i);

        nop(2'b00, 2'b00, 0, "reset_state");
        // EX->EX forward from MEM
        ins(1, 2, 1, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t1_add_x5");
        ins(5, 3, 1, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t1_add_x6");
        nop(2'b10, 2'b00, 0, "t1_fwdA_mem");
        nop(2'b00, 2'b00, 0, "t1_drain0");
        nop(2'b00, 2'b00, 0, "t1_drain1");
        // WB forward on rs2 after one unrelated instruction
        ins(1, 2, 1, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t2_add_x5");
        ins(10, 11, 1, 1, 9, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t2_unrel");
        ins(12, 5, 1, 1, 10, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t2_cons");
        nop(2'b00, 2'b01, 0, "t2_fwdB_wb");
        nop(2'b00, 2'b00, 0, "t2_drain");
        // newest writer wins
        ins(1, 2, 1, 1, 7, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t3_add_x7");
        ins(3, 4, 1, 1, 7, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t3_sub_x7");
        ins(7, 13, 1, 1, 11, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t3_cons");
        nop(2'b10, 2'b00, 0, "t3_fwdA_newest");
        nop(2'b00, 2'b00, 0, "t3_drain");
        // load-use: one stall, bubble, then WB forward
        ins(2, 0, 1, 0, 8, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0, "t4_lw_x8");
        ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0, "t4_stall");
        ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, "t4_bubble");
        nop(2'b01, 2'b00, 1, "t4_fwdA_wb");
        nop(2'b00, 2'b00, 1, "t4_drain");
        // flush beats stall
        ins(2, 0, 1, 0, 8, 1, 1, 1, 0, 2'b00, 2'b00, 0, 1, "t5_lw_x8");
        ins(8, 3, 1, 1, 13, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1, "t5_flush");
        nop(2'b00, 2'b00, 1, "t5_squashed0");
        nop(2'b00, 2'b00, 1, "t5_squashed1");
        // x0 never forwarded, load to x0 never stalls
        ins(1, 2, 1, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, "t6_add_x0a");
        ins(3, 4, 1, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, "t6_add_x0b");
        ins(0, 0, 1, 1, 14, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, "t6_rd_x0");
        nop(2'b00, 2'b00, 1, "t6_no_fwd_x0");
        ins(1, 0, 1, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 0, 1, "t6_lw_x0");
        ins(0, 3, 1, 1, 15, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, "t6_no_stall_x0");
        nop(2'b00, 2'b00, 1, "t6_drain");
        // reset on the stall edge: not counted, load discarded
        ins(2, 0, 1, 0, 8, 1, 1, 1, 0, 2'b00, 2'b00, 0, 1, "t7_lw_x8");
        ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 1, 1, "t7_stall_rst");
        rst_i = 1'b1;
        ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "t7_after_rst");
        nop(2'b00, 2'b00, 0, "t7_no_stale");
        // counter saturation
        for (int i = 0; i < 9; i++) begin
            c0 = (i < 7) ? i : 7;
            c1 = (i + 1 < 7) ? i + 1 : 7;
            ins(2, 0, 1, 0, 8, 1, 1, 1, 0, 2'b00, 2'b00, 0, c0, $sformatf("sat%0d_lw", i));
            ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 1, c0, $sformatf("sat%0d_stall", i));
            ins(8, 3, 1, 1, 12, 1, 0, 1, 0, 2'b00, 2'b00, 0, c1, $sformatf("sat%0d_bubble", i));
            nop(2'b01, 2'b00, c1, $sformatf("sat%0d_fwd", i));
        end
        drive_done = 1'b1;
    end

    initial begin
        wait (drive_done);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk_i);
        @(posedge clk_i);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Control-side counterpart of the EX-stage operand forwarding muxes in the 5-stage pipelined CPU.
- Tracks destination-register metadata of in-flight instructions through private ID/EX, EX/MEM and MEM/WB shadow registers.
- Drives the 2-bit Forward select for both ALU operands, plus the load-use stall request to PC, IF/ID and ID/EX.
- Sits beside the pipeline registers; consumes ID-stage decode fields and the branch flush.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of the saturating stall-event counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
ID_RS1_i  in  REG_AW  rs1 of instruction in ID
ID_RS2_i  in  REG_AW  rs2 of instruction in ID
ID_RS1_Use_i  in  1  instruction in ID reads rs1
ID_RS2_Use_i  in  1  instruction in ID reads rs2
ID_RD_i  in  REG_AW  rd of instruction in ID
ID_RegWrite_i  in  1  instruction in ID writes rd
ID_MemRead_i  in  1  instruction in ID is a load
ID_Valid_i  in  1  ID holds a real instruction
Flush_i  in  1  branch taken; squash instruction in ID
ForwardA_o  out  2  select for EX operand A
ForwardB_o  out  2  select for EX operand B
Stall_o  out  1  load-use hazard; hold PC and IF/ID, bubble ID/EX
StallCnt_o  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Select encoding (fixed, matches the EX operand muxes):
  - 00 = register-file data
  - 01 = WB write data
  - 10 = MEM ALU result
  - 11 is never driven.
- Shadow state is one entry per stage: IDEX {valid, rs1, rs2, rd, regwrite, memread}; EXMEM and MEMWB {valid, rd, regwrite, memread}.
- Reset (rst_i high at posedge): all valid bits 0, StallCnt_o = 0. Outputs derived from this state read ForwardA/B_o = 00 and Stall_o = 0 in the following cycle.
- Each posedge without reset:
  - MEMWB <= EXMEM and EXMEM <= IDEX, unconditionally. The pipeline never stalls past EX.
  - IDEX <= bubble (valid = 0) if Stall_o or Flush_i is high.
  - Otherwise IDEX <= ID fields, with valid = ID_Valid_i.
- Entry "writes r" means all of: valid && regwrite && rd != 0 && rd == r.
- ForwardA_o, combinational from registered state only:
  - 10 if EXMEM writes IDEX.rs1;
  - else 01 if MEMWB writes IDEX.rs1;
  - else 00.
  - MEM has priority because it holds the newest value.
- ForwardB_o: same rules using IDEX.rs2.
- Stall_o = IDEX.valid && IDEX.memread && IDEX.rd != 0 && ((ID_RS1_Use_i && IDEX.rd == ID_RS1_i) || (ID_RS2_Use_i && IDEX.rd == ID_RS2_i)) && ID_Valid_i && !Flush_i.
  - Combinational; 0-cycle latency from ID inputs.
- Simultaneous Stall condition and Flush_i: flush wins, so Stall_o = 0 and IDEX gets a bubble.
- A stall lasts exactly one cycle per load. The bubble removes the hazard on the next cycle, and the load then forwards via 01 from WB. The inserted bubble is the only stall.
- x0 is never forwarded: rd == 0 gives 00 even when regwrite = 1.
- Invariant (assertion): forward select 10 never occurs when EXMEM.memread = 1.
- StallCnt_o increments on each posedge where Stall_o = 1 and holds at all-ones (no wrap). A stall request seen on the same edge as reset is not counted.
- Reset mid-stall: the in-flight load is discarded, so there is no stale forwarding after reset.

Decomposition:
- Package fwd_pkg holds:
  - constants FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - typedef stage_meta_t {valid, rd, regwrite, memread}.
- One natural sub-module, fwd_select: combinational priority compare of one source register against the EXMEM/MEMWB metadata, returning a 2-bit select. It is instantiated twice (operands A and B).

Test Plan:
- add x5 in ID, then add x6 using rs1 = x5 one cycle later -> ForwardA_o = 10 in the consumer's EX cycle; ForwardB_o = 00.
- Producer writes x5, one unrelated instruction, then consumer reads x5 on rs2 -> ForwardB_o = 01, Stall_o = 0.
- Back-to-back writes: add x7 then sub x7, then consumer reads x7 -> ForwardA_o = 10 (newer value wins).
- lw x8, then add reading x8 on rs1 -> Stall_o = 1 for exactly one cycle; next cycle IDEX.valid = 0; consumer then sees ForwardA_o = 01; StallCnt_o = 1.
- lw x8 with consumer in ID and Flush_i = 1 on the same cycle -> Stall_o = 0, StallCnt_o unchanged, no later forward to the squashed instruction.
- Writes to x0 followed by a reader of x0 -> ForwardA/B_o = 00. Also assert rst_i mid-sequence -> next cycle all selects 00, Stall_o = 0, StallCnt_o = 0.
